// File: rtl/tx_link_ctrl.sv
// TX link-layer sequencer: tracks LMFC phase and SYNC~, steps the lane CGS -> ILA -> DATA,
// and reports re-synchronisation and link errors.
module tx_link_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int TMO_MARGIN  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_link_en,
   input  logic       i_sync_n,
   input  logic [7:0] i_F,
   input  logic [4:0] i_K,
   input  logic [7:0] i_ila_multiframe_length,
   input  logic       i_ila_seq_end,
   output logic       o_ila_start,
   output logic [4:0] o_no_frame_de_assertion,
   output logic [1:0] o_sel,
   output logic       o_data_ready,
   output logic       o_lmfc,
   output logic       o_resync,
   output logic       o_err_sync_glitch,
   output logic       o_err_ila_timeout
);

   typedef enum logic [1:0] {ST_CGS, ST_WAIT_LMFC, ST_ILA, ST_DATA} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [7:0]             oct_q, oct_d;
   logic [4:0]             frm_q, frm_d;
   logic [8:0]             mf_q, mf_d;
   logic [10:0]            low_q, low_d;
   logic [4:0]             nofr_q, nofr_d;
   logic [1:0]             sel_q, sel_d;
   logic                   rdy_q, rdy_d;
   logic                   lmfc_q, start_q, start_d;
   logic                   resync_q, resync_d, glitch_q, glitch_d, tmo_q, tmo_d;

   logic        sync_s;
   logic        lmfc_last;
   logic [10:0] thr;
   logic [10:0] low_inc;
   logic [9:0]  mf_lim;

   assign sync_s    = sync_q[SYNC_STAGES-1];
   assign lmfc_last = (oct_q == i_F) && (frm_q == i_K);
   assign thr       = ({3'b000, i_F} + 11'd1) * 11'd5 + 11'd9;
   assign low_inc   = low_q + 11'd1;
   assign mf_lim    = {2'b00, i_ila_multiframe_length} + 10'(TMO_MARGIN);

   always_comb begin
      oct_d    = oct_q + 8'd1;
      frm_d    = frm_q;
      state_d  = state_q;
      mf_d     = mf_q;
      low_d    = low_q;
      nofr_d   = nofr_q;
      start_d  = 1'b0;
      resync_d = 1'b0;
      glitch_d = 1'b0;
      tmo_d    = 1'b0;
      sel_d    = 2'b00;
      rdy_d    = 1'b0;

      // Phase counters free-run; >= keeps them bounded if the frame size shrinks under them
      if (oct_q >= i_F) begin
         oct_d = 8'd0;
         frm_d = (frm_q >= i_K) ? 5'd0 : frm_q + 5'd1;
      end

      if (state_q == ST_ILA && lmfc_last && mf_q != 9'h1FF) begin
         mf_d = mf_q + 9'd1;
      end

      if (!i_link_en) begin
         state_d = ST_CGS;
      end else begin
         case (state_q)
            ST_CGS: begin
               if (sync_s) begin
                  nofr_d  = frm_q;
                  state_d = ST_WAIT_LMFC;
               end
            end
            ST_WAIT_LMFC: begin
               if (!sync_s) begin
                  state_d = ST_CGS;
               end else if (lmfc_last) begin
                  start_d = 1'b1;
                  mf_d    = 9'd0;
                  state_d = ST_ILA;
               end
            end
            ST_ILA: begin
               if (!sync_s) begin
                  state_d = ST_CGS;
               end else if (i_ila_seq_end) begin
                  low_d   = 11'd0;
                  state_d = ST_DATA;
               end else if ({1'b0, mf_q} > mf_lim) begin
                  tmo_d   = 1'b1;
                  state_d = ST_CGS;
               end
            end
            ST_DATA: begin
               if (!sync_s) begin
                  if (low_inc >= thr) begin
                     resync_d = 1'b1;
                     state_d  = ST_CGS;
                  end else begin
                     low_d = low_inc;
                  end
               end else if (low_q != 11'd0) begin
                  glitch_d = 1'b1;
                  low_d    = 11'd0;
               end
            end
            default: state_d = ST_CGS;
         endcase
      end

      case (state_d)
         ST_ILA:  sel_d = 2'b01;
         ST_DATA: begin
            sel_d = 2'b10;
            rdy_d = 1'b1;
         end
         default: sel_d = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_CGS;
         sync_q   <= '0;
         oct_q    <= 8'd0;
         frm_q    <= 5'd0;
         mf_q     <= 9'd0;
         low_q    <= 11'd0;
         nofr_q   <= 5'd0;
         sel_q    <= 2'b00;
         rdy_q    <= 1'b0;
         lmfc_q   <= 1'b0;
         start_q  <= 1'b0;
         resync_q <= 1'b0;
         glitch_q <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync_q   <= {sync_q[SYNC_STAGES-2:0], i_sync_n};
         oct_q    <= oct_d;
         frm_q    <= frm_d;
         mf_q     <= mf_d;
         low_q    <= low_d;
         nofr_q   <= nofr_d;
         sel_q    <= sel_d;
         rdy_q    <= rdy_d;
         lmfc_q   <= lmfc_last;
         start_q  <= start_d;
         resync_q <= resync_d;
         glitch_q <= glitch_d;
         tmo_q    <= tmo_d;
      end
   end

   assign o_ila_start             = start_q;
   assign o_no_frame_de_assertion = nofr_q;
   assign o_sel                   = sel_q;
   assign o_data_ready            = rdy_q;
   assign o_lmfc                  = lmfc_q;
   assign o_resync                = resync_q;
   assign o_err_sync_glitch       = glitch_q;
   assign o_err_ila_timeout       = tmo_q;

endmodule
